nibble_down_counter: RTL and testbench
======================================

# nibble_down_counter

Cascadable, synchronous-load binary down-counter built from 4-bit slices. It is the counting-down counterpart of the team's loadable 4-bit up-counter next-state slice. It consumes the same style of controls: load, parallel enable, and trickle enable. It produces a borrow-out that ripples to the next slice and to downstream timers. Typical use is as a programmable interval or timeout counter whose borrow-out feeds the up-counter chain or a controller FSM.

## Interface
Parameters:
- NIB, 2, number of 4-bit slices; count width W = 4*NIB (NIB ≥ 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  synchronous parallel load of din.
- en_p  in  1  parallel (count) enable.
- en_t  in  1  trickle enable; also gates bo.
- din  in  W  load value.
- cnt  out  W  current count.
- tc  out  1  terminal count: cnt == 0 (combinational from state).
- bo  out  1  borrow-out: en_t & tc (combinational), cascade output.

## Operation
- Per-cycle priority: load > count > hold.
- load=1: cnt <= din, regardless of en_p/en_t.
- load=0, en_p=1, en_t=1, cnt≠0: cnt <= cnt-1 (mod 2^W).
- load=0, en_p=1, en_t=1, cnt==0 (underflow): cnt <= wrap value (see Configuration).
- Any other combination holds cnt.
- Slice chaining:
  - Slice 0 trickle-enable = en_t.
  - Slice k trickle-enable = en_t & (slices 0..k-1 all zero).
  - en_p goes to every slice.
  - A slice decrements only when en_p & its trickle-enable; its 0→F wrap borrows from the next slice.
  - The chained result must equal a plain W-bit decrement.
- bo is asserted in the same cycle in which an enabled underflow is registered at the next edge.
- bo is not gated by en_p. This matches the 74-series cascade rule: en_t carries the ripple, en_p gates local counting.

## Timing
- Reset: cnt = 0, so tc = 1 and bo = en_t. With the macro enabled, the reload register is also 0.
- rst acts immediately (asynchronously) and overrides load and count mid-operation.
- Release of rst is sampled at the next clk edge.
- Load latency: din is visible on cnt one cycle after load is sampled.
- Count latency: one decrement per enabled cycle, no bubbles.
- tc and bo have zero-cycle combinational latency from cnt/en_t.
- tc and bo must be glitch-free with respect to din and load (they depend only on cnt and en_t).
- Underflow boundary: in the cycle with cnt==0, en_p=1 and en_t=1, bo=1. The next cycle shows the wrap value.
- Simultaneous load and underflow: load wins, and bo still reflects the pre-edge state.

## Configuration
- DOWNCNT_AUTO_RELOAD_EN defined:
  - adds a W-bit reload register, written with din on every load;
  - on underflow, cnt <= reload value, giving a periodic timer of period reload+1 enabled cycles;
  - reload value 0 means cnt stays 0 and bo is high every enabled cycle.
- DOWNCNT_AUTO_RELOAD_EN undefined:
  - no reload register;
  - underflow wraps to 2^W-1 (all ones).

## Structure
- Shared package nibble_cnt_pkg:
  - NIB_W = 4;
  - the slice control struct type {load, en_p, en_t};
  - function all_ones(W).
- One sub-module, nibble_down_slice: a 4-bit register with load/enable/trickle. Its outputs are slice cnt[3:0] and slice zero flag.
- The top module generates NIB slice instances and the trickle-enable AND chain. It also holds the optional reload register.

## Test plan
- NIB=2, load din=0x12, then en_p=en_t=1 for 18 cycles -> cnt reaches 0x00 with tc=1 and bo=1. Next edge: cnt=0xFF (macro off) or 0x12 (macro on).
- cnt=0x10, one enabled cycle -> cnt=0x0F. This proves the low-slice borrow decremented the high slice.
- cnt=0x05: en_p=0, en_t=1 for 3 cycles -> cnt stays 0x05. At cnt=0x00 with en_t=0 -> bo=0 and tc=1.
- load=1 with din=0x80 while en_p=en_t=1 and cnt=0x00 -> bo=1 that cycle, and cnt=0x80 next cycle (load wins over underflow).
- Assert rst asynchronously mid-count at cnt=0x37 (between edges) -> cnt=0x00 immediately, and bo follows en_t. After release, load 0x03 counts normally.
- Macro on: load 0x00 and enable for 4 cycles -> cnt stays 0x00 and bo=1 every cycle.

Source files
------------

// File: rtl/nibble_cnt_pkg.sv
// Shared definitions for the nibble-sliced down-counter: slice width,
// per-slice control bundle and a small width helper.
package nibble_cnt_pkg;

  // Width of one counter slice.
  localparam int NIB_W = 4;

  // Controls delivered to each slice: load, parallel enable, trickle enable.
  typedef struct packed {
    logic load;
    logic en_p;
    logic en_t;
  } slice_ctrl_t;

  // All-ones value of width w (the natural underflow wrap value).
  function automatic logic [63:0] all_ones(input int w);
    if (w >= 64) begin
      all_ones = '1;
    end else begin
      all_ones = (64'd1 << w) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/nibble_down_slice.sv
// One 4-bit down-counting slice with synchronous load, parallel enable and
// trickle enable. A 0 -> F wrap is the borrow to the next slice; the top
// builds the trickle chain from the zero flags.
import nibble_cnt_pkg::*;

module nibble_down_slice (
  input  logic              clk,
  input  logic              rst,
  input  slice_ctrl_t       ctrl,
  input  logic [NIB_W-1:0]  din,
  output logic [NIB_W-1:0]  cnt,
  output logic              zero
);

  localparam logic [NIB_W-1:0] ONE = {{(NIB_W-1){1'b0}}, 1'b1};

  // Slice state: load beats count, count beats hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ctrl.load) begin
      cnt <= din;
    end else if (ctrl.en_p && ctrl.en_t) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nibble_down_counter.sv
// Cascadable down-counter of NIB 4-bit slices with load > count > hold
// priority. tc flags cnt == 0; bo = en_t & tc is the ripple/borrow output.
// Optional feature: define DOWNCNT_AUTO_RELOAD_EN to add a reload register
// (captured on every load) that replaces the all-ones wrap on underflow.
import nibble_cnt_pkg::*;

module nibble_down_counter #(
  parameter int NIB = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en_p,
  input  logic                 en_t,
  input  logic [NIB*NIB_W-1:0] din,
  output logic [NIB*NIB_W-1:0] cnt,
  output logic                 tc,
  output logic                 bo
);

  localparam int W = NIB * NIB_W;

  logic [NIB-1:0] zero;        // per-slice zero flags
  logic [NIB-1:0] te;          // per-slice trickle enables
  logic           underflow;   // enabled count while at zero
  logic           slice_load;  // load seen by every slice
  logic [W-1:0]   slice_din;   // value loaded into the slices

  slice_ctrl_t    ctrl [NIB];

  assign tc        = &zero;
  assign bo        = en_t & tc;
  assign underflow = en_p & en_t & tc;

`ifdef DOWNCNT_AUTO_RELOAD_EN
  logic [W-1:0] reload;

  // Reload register tracks the most recent load value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
    end else if (load) begin
      reload <= din;
    end
  end

  // On underflow the whole counter is reloaded instead of wrapping; an
  // explicit load still wins because it selects din.
  assign slice_load = load | underflow;
  assign slice_din  = load ? din : reload;
`else
  // Without reload, the chained 0 -> F wraps give the all-ones value.
  assign slice_load = load;
  assign slice_din  = din;

  logic unused_underflow;
  assign unused_underflow = underflow;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_slice
      // Slice gi trickles only when every lower slice is zero.
      if (gi == 0) begin : g_first
        assign te[gi] = en_t;
      end else begin : g_chain
        assign te[gi] = te[gi-1] & zero[gi-1];
      end

      assign ctrl[gi] = '{load: slice_load, en_p: en_p, en_t: te[gi]};

      nibble_down_slice u_slice (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl[gi]),
        .din  (slice_din[gi*NIB_W +: NIB_W]),
        .cnt  (cnt[gi*NIB_W +: NIB_W]),
        .zero (zero[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_nibble_down_counter.sv
// Scoreboard bench for nibble_down_counter (NIB=2). Stimulus pushes the
// hand-computed expected outputs; an independent monitor pops and compares.
module tb_nibble_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       en_p = 1'b0;
  logic       en_t = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] cnt;
  logic       tc;
  logic       bo;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DOWNCNT_AUTO_RELOAD_EN
  localparam logic [7:0] WRAP_A = 8'h12;
  localparam logic [7:0] WRAP_B = 8'h03;
`else
  localparam logic [7:0] WRAP_A = 8'hFF;
  localparam logic [7:0] WRAP_B = 8'hFF;
`endif

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       tc;
    logic       bo;
  } exp_t;

  exp_t exp_q[$];

  nibble_down_counter #(.NIB(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en_p (en_p),
    .en_t (en_t),
    .din  (din),
    .cnt  (cnt),
    .tc   (tc),
    .bo   (bo)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic l, input logic p, input logic t, input logic [7:0] d);
    @(posedge clk);
    #1;
    load = l;
    en_p = p;
    en_t = t;
    din  = d;
  endtask

  task automatic expect_out(input string nm, input logic [7:0] c, input logic tcv, input logic bov);
    exp_t e;
    e.name = nm;
    e.cnt  = c;
    e.tc   = tcv;
    e.bo   = bov;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs settle 1 time unit after an expectation is issued.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (cnt !== e.cnt || tc !== e.tc || bo !== e.bo) begin
        n_fail++;
        $display("FAIL %s: got cnt=%02h tc=%0b bo=%0b, want cnt=%02h tc=%0b bo=%0b",
                 e.name, cnt, tc, bo, e.cnt, e.tc, e.bo);
      end else begin
        $display("ok   %s: cnt=%02h tc=%0b bo=%0b", e.name, cnt, tc, bo);
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    drive(0, 0, 0, 8'h00); expect_out("reset_en_t0", 8'h00, 1, 0);
    drive(0, 0, 1, 8'h00); expect_out("reset_en_t1", 8'h00, 1, 1);
    drive(1, 0, 0, 8'h12); rst = 1'b0; expect_out("rel_load12", 8'h00, 1, 0);

    // Count 0x12 down to zero, then underflow.
    for (int i = 0; i < 18; i++) begin
      drive(0, 1, 1, 8'h00);
      expect_out($sformatf("count_%0d", i), 8'(8'h12 - i), 0, 0);
    end
    drive(0, 1, 1, 8'h00); expect_out("at_zero_enabled", 8'h00, 1, 1);
    drive(0, 0, 0, 8'h00); expect_out("wrap_after_18", WRAP_A, 0, 0);

    // Borrow across slices.
    drive(1, 0, 0, 8'h10); expect_out("pre_load10", WRAP_A, 0, 0);
    drive(0, 1, 1, 8'h00); expect_out("cnt_10", 8'h10, 0, 0);
    drive(0, 0, 0, 8'h00); expect_out("borrow_0f", 8'h0F, 0, 0);

    // en_p low holds; en_t low blocks bo at zero.
    drive(1, 0, 0, 8'h05); expect_out("pre_load05", 8'h0F, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'h00);
      expect_out($sformatf("hold_05_%0d", i), 8'h05, 0, 0);
    end
    drive(1, 0, 0, 8'h00); expect_out("still_05", 8'h05, 0, 0);
    drive(0, 1, 0, 8'h00); expect_out("zero_en_t0", 8'h00, 1, 0);

    // Load beats underflow; bo reflects the pre-edge state.
    drive(1, 1, 1, 8'h80); expect_out("load_vs_uf", 8'h00, 1, 1);
    drive(0, 0, 0, 8'h00); expect_out("loaded_80", 8'h80, 0, 0);

    // Asynchronous reset between edges.
    drive(1, 0, 0, 8'h37); expect_out("pre_load37", 8'h80, 0, 0);
    drive(0, 1, 1, 8'h00); expect_out("cnt_37", 8'h37, 0, 0);
    #2; rst = 1'b1;        expect_out("async_rst", 8'h00, 1, 1);
    drive(0, 1, 1, 8'h00); expect_out("rst_held", 8'h00, 1, 1);
    drive(1, 0, 0, 8'h03); rst = 1'b0; expect_out("rst_rel", 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 8'h00);
      expect_out($sformatf("post_rst_%0d", i), 8'(8'h03 - i), 0, 0);
    end
    drive(0, 1, 1, 8'h00); expect_out("post_rst_zero", 8'h00, 1, 1);
    drive(0, 0, 0, 8'h00); expect_out("post_rst_wrap", WRAP_B, 0, 0);

`ifdef DOWNCNT_AUTO_RELOAD_EN
    // Reload value zero keeps cnt at zero with bo every enabled cycle.
    drive(1, 0, 0, 8'h00); expect_out("pre_reload0", WRAP_B, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 8'h00);
      expect_out($sformatf("reload0_%0d", i), 8'h00, 1, 1);
    end
    drive(0, 0, 0, 8'h00); expect_out("reload0_end", 8'h00, 1, 0);
`endif

    #20;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
